// File: rtl/ram_dual_port_pipe_if.sv
// Per-port request/response bundle for ram_dual_port_pipe; one instance per port.
interface ram_dual_port_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   byteena;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;

    modport master (output valid, wren, address, data, byteena, input q, q_valid);
    modport slave  (input valid, wren, address, data, byteena, output q, q_valid);
endinterface

// File: rtl/ram_dual_port_pipe.sv
// True dual-port byte-enabled RAM with a LATENCY-deep read pipeline per port.
// Define RAM_DP_COLLISION_DETECT_EN to add the collision / collision_count outputs.
module ram_dual_port_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    ram_dual_port_pipe_if.slave a,
    ram_dual_port_pipe_if.slave b
`ifdef RAM_DP_COLLISION_DETECT_EN
    ,
    output logic        collision,
    output logic [15:0] collision_count
`endif
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]                 req_v, req_w, in_rng, acc, acc_rd, acc_wr;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][IW-1:0]         idx;
    logic [1:0][DATA_WIDTH-1:0] req_data, rd_word, q_o;
    logic [1:0][BE_WIDTH-1:0]   req_be;
    logic [1:0]                 qv_o;

    always_comb begin
        req_v    = {b.valid, a.valid};
        req_w    = {b.wren, a.wren};
        req_addr = {b.address, a.address};
        req_data = {b.data, a.data};
        req_be   = {b.byteena, a.byteena};
        for (int p = 0; p < 2; p++) begin
            in_rng[p]  = 32'(req_addr[p]) < 32'(DEPTH);
            idx[p]     = IW'(req_addr[p]);
            acc[p]     = clken && !reset && req_v[p];
            acc_rd[p]  = acc[p] && !req_w[p];
            acc_wr[p]  = acc[p] && req_w[p] && in_rng[p];
            // Read before this cycle's writes land, so a cross-port read sees old data
            rd_word[p] = in_rng[p] ? mem_q[idx[p]] : '0;
        end
    end

    assign a.q       = q_o[0];
    assign a.q_valid = qv_o[0];
    assign b.q       = q_o[1];
    assign b.q_valid = qv_o[1];

    // B is written first so that A's enabled bytes win on a same-address write pair
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (acc_wr[1] && req_be[1][i]) mem_q[idx[1]][i*8 +: 8] <= req_data[1][i*8 +: 8];
            if (acc_wr[0] && req_be[0][i]) mem_q[idx[0]][i*8 +: 8] <= req_data[0][i*8 +: 8];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
        logic [LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

        always_comb begin
            vld_pipe_d = vld_pipe_q;
            dat_pipe_d = dat_pipe_q;
            if (clken) begin
                vld_pipe_d[0] = acc_rd[p];
                dat_pipe_d[0] = acc_rd[p] ? rd_word[p] : '0;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_pipe_d[i] = vld_pipe_q[i-1];
                    dat_pipe_d[i] = dat_pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_pipe_q <= '0;
                dat_pipe_q <= '0;
            end else begin
                vld_pipe_q <= vld_pipe_d;
                dat_pipe_q <= dat_pipe_d;
            end
        end

        assign qv_o[p] = vld_pipe_q[LATENCY-1];
        assign q_o[p]  = dat_pipe_q[LATENCY-1];
    end

`ifdef RAM_DP_COLLISION_DETECT_EN
    logic        coll_d, coll_q;
    logic [15:0] ccnt_d, ccnt_q;

    always_comb begin
        coll_d = acc[0] && acc[1] && (req_addr[0] == req_addr[1]) && (req_w[0] || req_w[1]);
        ccnt_d = (coll_d && ccnt_q != 16'hFFFF) ? 16'(ccnt_q + 16'd1) : ccnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_q <= 1'b0;
            ccnt_q <= '0;
        end else if (clken) begin
            coll_q <= coll_d;
            ccnt_q <= ccnt_d;
        end
    end

    assign collision       = coll_q;
    assign collision_count = ccnt_q;
`endif
endmodule

// File: tb/tb_ram_dual_port_pipe.sv
// Self-checking bench for ram_dual_port_pipe: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ram_dual_port_pipe;
    localparam int DW = 32, AW = 8, DEPTH = 200, LAT = 2;

    logic clk = 1'b0;
    logic reset, clken;
    always #5 clk = ~clk;

    ram_dual_port_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
    ram_dual_port_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();
`ifdef RAM_DP_COLLISION_DETECT_EN
    logic        collision;
    logic [15:0] collision_count;
`endif

    ram_dual_port_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .clken(clken), .a(ifa), .b(ifb)
`ifdef RAM_DP_COLLISION_DETECT_EN
        , .collision(collision), .collision_count(collision_count)
`endif
    );

    typedef struct { logic v; logic w; logic [AW-1:0] ad; logic [DW-1:0] d; logic [3:0] be; } req_t;
    typedef struct { int due; logic [DW-1:0] d; } res_t;

    req_t          r [2];
    res_t          pq [2][$];
    logic [DW-1:0] mmem [DEPTH];
    int            en_cnt;
    logic [1:0]    e_qv;
    logic [DW-1:0] e_q [2];
    logic          e_coll;
    int            e_ccnt;
    int            checks, failures;

    // Reference model: results are queued with the enabled-cycle index at which they must appear
    task automatic model(input logic rst, input logic en);
        if (rst) begin
            pq[0].delete(); pq[1].delete();
            e_qv = '0; e_q[0] = '0; e_q[1] = '0; e_coll = 1'b0; e_ccnt = 0;
        end else if (en) begin
            en_cnt++;
            for (int p = 0; p < 2; p++) begin
                if (r[p].v && !r[p].w) begin
                    res_t t;
                    int ad;
                    ad = int'(r[p].ad);
                    t.due = en_cnt + LAT - 1;
                    t.d = (ad < DEPTH) ? mmem[ad] : '0;
                    pq[p].push_back(t);
                end
            end
            e_coll = r[0].v && r[1].v && (r[0].ad == r[1].ad) && (r[0].w || r[1].w);
            if (e_coll && e_ccnt < 65535) e_ccnt++;
            for (int p = 1; p >= 0; p--) begin
                int ad;
                ad = int'(r[p].ad);
                if (r[p].v && r[p].w && ad < DEPTH)
                    for (int i = 0; i < 4; i++)
                        if (r[p].be[i]) mmem[ad][i*8 +: 8] = r[p].d[i*8 +: 8];
            end
            for (int p = 0; p < 2; p++) begin
                if (pq[p].size() > 0 && pq[p][0].due == en_cnt) begin
                    e_qv[p] = 1'b1; e_q[p] = pq[p][0].d; void'(pq[p].pop_front());
                end else begin
                    e_qv[p] = 1'b0; e_q[p] = '0;
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic en);
        ifa.valid = r[0].v; ifa.wren = r[0].w; ifa.address = r[0].ad; ifa.data = r[0].d; ifa.byteena = r[0].be;
        ifb.valid = r[1].v; ifb.wren = r[1].w; ifb.address = r[1].ad; ifb.data = r[1].d; ifb.byteena = r[1].be;
        reset = rst; clken = en;
        @(posedge clk);
        model(rst, en);
        #1;
        r[0].v = 1'b0; r[1].v = 1'b0;
    endtask

    task automatic set_req(input int p, input logic w, input int ad, input logic [DW-1:0] d, input logic [3:0] be);
        r[p].v = 1'b1; r[p].w = w; r[p].ad = AW'(ad); r[p].d = d; r[p].be = be;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1);
        checks++;
        if ({ifa.q_valid, ifa.q, ifb.q_valid, ifb.q} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {ifa.q_valid, ifa.q, ifb.q_valid, ifb.q});
        end
`ifdef RAM_DP_COLLISION_DETECT_EN
        checks++;
        if ({collision, collision_count} !== 17'd0) begin
            failures++; $display("FAIL reset_collision got=%h exp=0", {collision, collision_count});
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1'b1, i, $urandom, 4'hF);
            step(1'b0, 1'b1);
            checks++;
            if ({ifa.q_valid, ifb.q_valid} !== 2'b00) begin
                failures++; $display("FAIL write_no_qvalid addr=%0d got=%b exp=00", i, {ifa.q_valid, ifb.q_valid});
            end
        end
    endtask

    task automatic test_collision;
        set_req(0, 1'b1, 7, 32'h1, 4'hF);
        step(1'b0, 1'b1);
        set_req(0, 1'b1, 7, 32'h2, 4'hF);
        set_req(1, 1'b0, 7, '0, 4'h0);
        step(1'b0, 1'b1);
`ifdef RAM_DP_COLLISION_DETECT_EN
        checks++;
        if ({collision, collision_count} !== {1'b1, 16'd1}) begin
            failures++; $display("FAIL collision_pulse got=%h exp=%h", {collision, collision_count}, {1'b1, 16'd1});
        end
`endif
        step(1'b0, 1'b1);
        checks++;
        if ({ifb.q_valid, ifb.q} !== {1'b1, 32'h1}) begin
            failures++; $display("FAIL rw_old_data got=%h exp=%h", {ifb.q_valid, ifb.q}, {1'b1, 32'h1});
        end
`ifdef RAM_DP_COLLISION_DETECT_EN
        checks++;
        if ({collision, collision_count} !== {1'b0, 16'd1}) begin
            failures++; $display("FAIL collision_once got=%h exp=%h", {collision, collision_count}, {1'b0, 16'd1});
        end
`endif
        set_req(1, 1'b0, 7, '0, 4'h0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({ifb.q_valid, ifb.q} !== {1'b1, 32'h2}) begin
            failures++; $display("FAIL rw_new_data got=%h exp=%h", {ifb.q_valid, ifb.q}, {1'b1, 32'h2});
        end
    endtask

    task automatic test_directed;
        set_req(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        step(1'b0, 1'b1);
        set_req(1, 1'b0, 5, '0, 4'h0);
        step(1'b0, 1'b1);
        checks++;
        if (ifb.q_valid !== 1'b0) begin
            failures++; $display("FAIL latency_early got=%b exp=0", ifb.q_valid);
        end
        step(1'b0, 1'b1);
        checks++;
        if ({ifb.q_valid, ifb.q} !== {1'b1, 32'hDEADBEEF}) begin
            failures++; $display("FAIL wr_a_rd_b got=%h exp=%h", {ifb.q_valid, ifb.q}, {1'b1, 32'hDEADBEEF});
        end
        set_req(0, 1'b1, 3, 32'h11223344, 4'hF);
        step(1'b0, 1'b1);
        set_req(0, 1'b1, 3, 32'hAAAAAAAA, 4'h3);
        set_req(1, 1'b1, 3, 32'hBBBBBBBB, 4'hC);
        step(1'b0, 1'b1);
        set_req(0, 1'b0, 3, '0, 4'h0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({ifa.q_valid, ifa.q} !== {1'b1, 32'hBBBBAAAA}) begin
            failures++; $display("FAIL byte_arbitration got=%h exp=%h", {ifa.q_valid, ifa.q}, {1'b1, 32'hBBBBAAAA});
        end
        set_req(0, 1'b1, 3, 32'hCCCCCCCC, 4'h5);
        set_req(1, 1'b1, 3, 32'hDDDDDDDD, 4'hF);
        step(1'b0, 1'b1);
        set_req(1, 1'b0, 3, '0, 4'h0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({ifb.q_valid, ifb.q} !== {1'b1, 32'hDDCCDDCC}) begin
            failures++; $display("FAIL a_wins_overlap got=%h exp=%h", {ifb.q_valid, ifb.q}, {1'b1, 32'hDDCCDDCC});
        end
    endtask

    task automatic test_clken_stall;
        logic [DW-1:0] held;
        set_req(0, 1'b0, 10, '0, 4'h0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 10, $urandom, 4'hF);
            set_req(1, 1'b0, 11, '0, 4'h0);
            step(1'b0, 1'b0);
            checks++;
            if (ifa.q_valid !== 1'b0) begin
                failures++; $display("FAIL stall_no_valid cyc=%0d got=%b exp=0", i, ifa.q_valid);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if ({ifa.q_valid, ifa.q} !== {1'b1, mmem[10]}) begin
            failures++; $display("FAIL stall_result got=%h exp=%h", {ifa.q_valid, ifa.q}, {1'b1, mmem[10]});
        end
        held = mmem[10];
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1'b0, 12, '0, 4'h0);
            step(1'b0, 1'b0);
            checks++;
            if ({ifa.q_valid, ifa.q, ifb.q_valid} !== {1'b1, held, 1'b0}) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, {ifa.q_valid, ifa.q, ifb.q_valid}, {1'b1, held, 1'b0});
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if ({ifa.q_valid, ifa.q} !== {1'b0, 32'h0}) begin
            failures++; $display("FAIL stall_release got=%h exp=0", {ifa.q_valid, ifa.q});
        end
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, 20 + i, '0, 4'h0);
            set_req(1, 1'b0, 30 + i, '0, 4'h0);
            step(i >= 2, i != 3);
            if (i >= 2) begin
                checks++;
                if ({ifa.q_valid, ifa.q, ifb.q_valid, ifb.q} !== '0) begin
                    failures++; $display("FAIL reset_flush cyc=%0d got=%h exp=0", i, {ifa.q_valid, ifa.q, ifb.q_valid, ifb.q});
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({ifa.q_valid, ifa.q, ifb.q_valid, ifb.q} !== '0) begin
                failures++; $display("FAIL reset_no_late cyc=%0d got=%h exp=0", i, {ifa.q_valid, ifa.q, ifb.q_valid, ifb.q});
            end
        end
    endtask

    task automatic test_out_of_range;
        set_req(0, 1'b1, 250, 32'hFF, 4'hF);
        step(1'b0, 1'b1);
        set_req(1, 1'b0, 250, '0, 4'h0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({ifb.q_valid, ifb.q} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL oor_read got=%h exp=%h", {ifb.q_valid, ifb.q}, {1'b1, 32'h0});
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < DEPTH + LAT; i++) begin
            if (i < DEPTH) begin
                set_req(0, 1'b0, i, '0, 4'h0);
                set_req(1, 1'b0, DEPTH - 1 - i, '0, 4'h0);
            end
            step(1'b0, 1'b1);
            checks++;
            if ({ifa.q_valid, ifa.q, ifb.q_valid, ifb.q} !== {e_qv[0], e_q[0], e_qv[1], e_q[1]}) begin
                failures++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, {ifa.q_valid, ifa.q, ifb.q_valid, ifb.q}, {e_qv[0], e_q[0], e_qv[1], e_q[1]});
            end
            if (i >= LAT - 1 && i < DEPTH + LAT - 1) begin
                checks++;
                if ({ifa.q_valid, ifb.q_valid} !== 2'b11) begin
                    failures++; $display("FAIL b2b_throughput cyc=%0d got=%b exp=11", i, {ifa.q_valid, ifb.q_valid});
                end
            end
        end
    endtask

    task automatic test_random;
        logic rst, en;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 3) != 0)
                    set_req(p, 1'(($urandom_range(0, 2)) == 0),
                            ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)),
                            $urandom, 4'($urandom_range(0, 15)));
            rst = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 7) != 0);
            step(rst, en);
            checks++;
            if ({ifa.q_valid, ifa.q, ifb.q_valid, ifb.q} !== {e_qv[0], e_q[0], e_qv[1], e_q[1]}) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, {ifa.q_valid, ifa.q, ifb.q_valid, ifb.q}, {e_qv[0], e_q[0], e_qv[1], e_q[1]});
            end
`ifdef RAM_DP_COLLISION_DETECT_EN
            checks++;
            if ({collision, collision_count} !== {e_coll, 16'(e_ccnt)}) begin
                failures++; $display("FAIL random_collision cyc=%0d got=%h exp=%h", i, {collision, collision_count}, {e_coll, 16'(e_ccnt)});
            end
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1'b0, i, '0, 4'h0);
            step(1'b0, 1'b1);
            checks++;
            if ({ifa.q_valid, ifa.q} !== {e_qv[0], e_q[0]}) begin
                failures++; $display("FAIL final_sweep addr=%0d got=%h exp=%h", i, {ifa.q_valid, ifa.q}, {e_qv[0], e_q[0]});
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; en_cnt = 0;
        e_qv = '0; e_q[0] = '0; e_q[1] = '0; e_coll = 1'b0; e_ccnt = 0;
        for (int p = 0; p < 2; p++) begin
            r[p].v = 1'b0; r[p].w = 1'b0; r[p].ad = '0; r[p].d = '0; r[p].be = '0;
        end
        test_reset;
        test_collision;
        test_directed;
        test_clken_stall;
        test_reset_midflight;
        test_out_of_range;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_dual_port_pipe.md
RAM_DUAL_PORT_PIPE -- requirements
Module: ram_dual_port_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning address width of both ports.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of words; must be at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter LATENCY, default 2, meaning read latency in enabled cycles; range 1..8.
REQ-005 SHALL have derived parameter BE_WIDTH = DATA_WIDTH/8.
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: clken  in  1  global enable; low freezes the block.
REQ-009 SHALL have ports, for each port P in {a,b}: valid_P  in  1  request strobe.
REQ-010 SHALL have ports, for each port P in {a,b}: wren_P  in  1  1=write, 0=read.
REQ-011 SHALL have ports, for each port P in {a,b}: address_P  in  ADDR_WIDTH  word address.
REQ-012 SHALL have ports, for each port P in {a,b}: data_P  in  DATA_WIDTH  write data.
REQ-013 SHALL have ports, for each port P in {a,b}: byteena_P  in  BE_WIDTH  per-byte write enable.
REQ-014 SHALL have ports, for each port P in {a,b}: q_P  out  DATA_WIDTH  read data.
REQ-015 SHALL have ports, for each port P in {a,b}: q_valid_P  out  1  q_P holds read result.

Function
REQ-016 SHALL accept a request on port P in a cycle where clken=1, reset=0 and valid_P=1; no backpressure exists.
REQ-017 SHALL, for an accepted write, update only the bytes whose byteena_P bit is 1 at the end of that cycle.
REQ-018 SHALL, for an accepted read, drive q_valid_P=1 and q_P=word exactly LATENCY enabled cycles after acceptance; writes produce no q_valid.
REQ-019 SHALL give back-to-back reads full throughput: one result per enabled cycle per port, independently per port.
REQ-020 SHALL, while clken=0, hold every pipeline stage, q_P and q_valid_P, ignore requests and leave memory unchanged.
REQ-021 SHALL drive q_P to all zeros whenever q_valid_P=0.
REQ-022 SHALL, when the same address is read on one port and written on the other in the same cycle, return OLD data to the reader.
REQ-023 SHALL, when the same address is read and written on the same port, not occur: wren selects write only.
REQ-024 SHALL, when both ports write the same address in one cycle, apply per-byte arbitration: bytes enabled on A take A data; bytes enabled only on B take B data.
REQ-025 SHALL ignore writes with address >= DEPTH and return zero data with q_valid=1 for reads with address >= DEPTH.
REQ-026 SHALL not initialise memory contents; reads of never-written words return undefined data in simulation (X allowed).

Reset
REQ-027 SHALL, on reset=1 at a rising edge, clear all pipeline valid bits, q_valid_a/b to 0 and q_a/b to 0, regardless of clken.
REQ-028 SHALL drop in-flight reads when reset asserts mid-operation; none emerge after reset deasserts.
REQ-029 SHALL leave memory contents untouched by reset, and SHALL ignore requests presented while reset=1.

Configuration
REQ-030 SHALL, with macro RAM_DP_COLLISION_DETECT_EN defined, add output collision (1 bit) pulsing high one enabled cycle after any same-address, same-cycle access pair on A and B where at least one is a write.
REQ-031 SHALL, with RAM_DP_COLLISION_DETECT_EN defined, add output collision_count (16 bits), incrementing once per such cycle, saturating at 0xFFFF, and cleared by reset.
REQ-032 SHALL, without RAM_DP_COLLISION_DETECT_EN, omit both ports and logic; data behaviour, including REQ-022 and REQ-024, is identical.

Verification
REQ-033 SHALL cover this scenario: LATENCY=2, write A addr 5 = 0xDEADBEEF with be=0xF, then read B addr 5 -> q_valid_b high 2 cycles later, q_b=0xDEADBEEF.
REQ-034 SHALL cover this scenario: addr 3 = 0x11223344; same cycle A writes 0xAAAAAAAA with be=0x3 and B writes 0xBBBBBBBB with be=0xC; next, read addr 3 -> 0xBBBBAAAA.
REQ-035 SHALL cover this scenario: addr 7 = 0x1; same cycle A writes 0x2 and B reads addr 7 -> q_b=0x1; a subsequent read returns 0x2; with the macro, collision=1 once and collision_count=1.
REQ-036 SHALL cover this scenario: read issued, clken low 3 cycles after acceptance -> q_valid delayed exactly 3 cycles, q stable throughout.
REQ-037 SHALL cover this scenario: 4 back-to-back reads, reset asserted on the 3rd cycle -> q_valid and q are 0 next cycle and no further results appear.
REQ-038 SHALL cover this scenario: DEPTH=200, write 0xFF to addr 250, read addr 250 -> q_valid=1, q=0; words 0..199 are unchanged.
